// File: rtl/serial_borrow_lookahead_subtractor.sv
// -----------------------------------------------------------------------------
// serial_borrow_lookahead_subtractor
//
// Multi-cycle subtractor that computes diff = a - b - bin modulo 2^WIDTH. It
// processes one DIGIT-wide slice per clock, starting with the LSB slice. Each
// slice resolves its internal borrows with lookahead (sum-of-products) logic.
// The borrow out of each slice is registered and feeds the next slice.
//
// Optional build macro: SUB_STATUS_FLAGS_EN adds the zero and ovf outputs.
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset
//   start  request, sampled only while idle
//   a, b   minuend / subtrahend, captured on an accepted start
//   bin    borrow-in, captured on an accepted start
//   busy   high while a subtraction is in flight
//   done   one-cycle pulse; diff/bout valid (held until the next done)
//   diff   WIDTH-bit result
//   bout   borrow-out, 1 iff a < b + bin (unsigned)
//   zero   (SUB_STATUS_FLAGS_EN) diff == 0
//   ovf    (SUB_STATUS_FLAGS_EN) two's-complement overflow of the subtraction
// -----------------------------------------------------------------------------
module serial_borrow_lookahead_subtractor #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SUB_STATUS_FLAGS_EN
  ,
  output logic             zero,
  output logic             ovf
`endif
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if ((DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_bad_params
    $error("WIDTH must be a positive integer multiple of DIGIT");
  end

  typedef enum logic {IDLE, RUN} state_e;

  state_e            state_q,  state_d;
  logic [CW-1:0]     cnt_q,    cnt_d;
  logic [WIDTH-1:0]  a_q,      a_d;
  logic [WIDTH-1:0]  b_q,      b_d;
  logic              borrow_q, borrow_d;
  logic [WIDTH-1:0]  acc_q,    acc_d;
  logic [WIDTH-1:0]  diff_q,   diff_d;
  logic              bout_q,   bout_d;
  logic              done_q,   done_d;
`ifdef SUB_STATUS_FLAGS_EN
  logic              zero_q,   zero_d;
  logic              ovf_q,    ovf_d;
`endif

  // Slice datapath signals
  logic [DIGIT-1:0]  slice_a, slice_b, slice_g, slice_p, slice_d;
  logic [DIGIT:0]    slice_bw;
  logic [WIDTH-1:0]  acc_next;
  int                base;

  // Borrow lookahead for the current slice. Each borrow is formed directly as
  // g[j] | p[j]g[j-1] | ... | p[j..0]borrow_in. It does not ripple through
  // the lower bits.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    base     = int'(cnt_q) * DIGIT;
    slice_a  = a_q[base +: DIGIT];
    slice_b  = b_q[base +: DIGIT];
    slice_g  = ~slice_a & slice_b;
    slice_p  = ~(slice_a ^ slice_b);
    slice_bw = '0;
    slice_bw[0] = borrow_q;
    for (int j = 0; j < DIGIT; j++) begin
      logic pp;
      logic bw;
      pp = 1'b1;
      bw = 1'b0;
      for (int k = j; k >= 0; k--) begin
        bw = bw | (pp & slice_g[k]);
        pp = pp & slice_p[k];
      end
      slice_bw[j+1] = bw | (pp & borrow_q);
    end
    slice_d  = slice_a ^ slice_b ^ slice_bw[DIGIT-1:0];
    acc_next = acc_q;
    acc_next[base +: DIGIT] = slice_d;
  end

  // Next-state and register update logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    borrow_d = borrow_q;
    acc_d    = acc_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    done_d   = 1'b0;
`ifdef SUB_STATUS_FLAGS_EN
    zero_d   = zero_q;
    ovf_d    = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          // The borrow-in is loaded straight into the slice-borrow register.
          // It then acts as slice 0's incoming borrow.
          borrow_d = bin;
          cnt_d    = '0;
          acc_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d    = acc_next;
        borrow_d = slice_bw[DIGIT];
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // The visible result changes only here, so diff/bout hold between ops.
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
          diff_d  = acc_next;
          bout_d  = slice_bw[DIGIT];
`ifdef SUB_STATUS_FLAGS_EN
          zero_d  = (acc_next == '0);
          ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                    (acc_next[WIDTH-1] != a_q[WIDTH-1]);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. All flops then
  // update together from values sampled before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the operand registers are reset as well. They are only read in
      // RUN, but clearing them keeps every flop at a known value after reset.
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      acc_q    <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SUB_STATUS_FLAGS_EN
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      borrow_q <= borrow_d;
      acc_q    <= acc_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      done_q   <= done_d;
`ifdef SUB_STATUS_FLAGS_EN
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
`ifdef SUB_STATUS_FLAGS_EN
  assign zero = zero_q;
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_borrow_lookahead_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_borrow_lookahead_subtractor
//
// Scoreboard bench for serial_borrow_lookahead_subtractor (WIDTH=8, DIGIT=4).
// Each issued operation pushes its hand-computed result into a queue. A
// monitor pops an entry and compares it on every done pulse. The stimulus
// thread also checks busy/done timing directly.
// Build with SUB_STATUS_FLAGS_EN to also check the zero and ovf outputs.
// -----------------------------------------------------------------------------
module tb_serial_borrow_lookahead_subtractor;

  typedef struct packed {
    logic [7:0] diff;
    logic       bout;
    logic       zero;
    logic       ovf;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a, b;
  logic       bin;
  logic       busy, done, bout;
  logic [7:0] diff;
`ifdef SUB_STATUS_FLAGS_EN
  logic       zero, ovf;
`endif

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];

  serial_borrow_lookahead_subtractor #(.WIDTH(8), .DIGIT(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SUB_STATUS_FLAGS_EN
    ,
    .zero  (zero),
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Drive a start request on the current cycle. The expected result is
  // supplied by the caller and pushed to the scoreboard.
  task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic ibin,
                       input logic [7:0] ed, input logic eb, input logic eo);
    exp_t e;
    start = 1'b1;
    a     = ia;
    b     = ib;
    bin   = ibin;
    e.diff = ed;
    e.bout = eb;
    e.zero = (ed == 8'h00);
    e.ovf  = eo;
    sb_q.push_back(e);
  endtask

  // One complete op. Checks busy for exactly two cycles and done on the third
  // sample, which falls two edges after the accepting edge.
  task automatic run_op(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                        input logic ibin, input logic [7:0] ed, input logic eb,
                        input logic eo);
    cyc();
    issue(ia, ib, ibin, ed, eb, eo);
    cyc();
    start = 1'b0;
    check({tag, "_busy1"}, busy, 1);
    check({tag, "_nodone1"}, done, 0);
    cyc();
    check({tag, "_busy2"}, busy, 1);
    cyc();
    check({tag, "_done"}, done, 1);
    check({tag, "_idle"}, busy, 0);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst === 1'b0 && done === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1, expected no pending op at %0t", $time);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_diff", diff, e.diff);
        check("sb_bout", bout, e.bout);
`ifdef SUB_STATUS_FLAGS_EN
        check("sb_zero", zero, e.zero);
        check("sb_ovf",  ovf,  e.ovf);
`endif
      end
    end
  end

  initial begin
    // Reset with start asserted: start must be ignored
    rst = 1'b1; start = 1'b1; a = 8'hFF; b = 8'h01; bin = 1'b0;
    cyc();
    cyc();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_diff", diff, 0);
    check("rst_bout", bout, 0);
`ifdef SUB_STATUS_FLAGS_EN
    check("rst_zero", zero, 0);
    check("rst_ovf",  ovf,  0);
`endif
    rst = 1'b0; start = 1'b0;
    cyc();
    check("post_rst_idle", busy, 0);

    // Basic cases
    run_op("zero",  8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    run_op("xslice", 8'h0F, 8'h01, 1'b0, 8'h0E, 1'b0, 1'b0);
    run_op("aa55",  8'hAA, 8'h55, 1'b1, 8'h54, 1'b0, 1'b1);
    // Wrap-around
    run_op("wrap0", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
    run_op("wrapff", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);

    // start while busy is ignored
    cyc();
    issue(8'h3C, 8'h1E, 1'b0, 8'h1E, 1'b0, 1'b0);
    cyc();
    check("ign_busy1", busy, 1);
    start = 1'b1; a = 8'h00; b = 8'hFF; bin = 1'b1;
    cyc();
    check("ign_busy2", busy, 1);
    start = 1'b0;
    cyc();
    check("ign_done", done, 1);
    check("ign_idle", busy, 0);
    cyc();
    check("ign_nodone", done, 0);
    check("ign_still_idle", busy, 0);
    check("ign_hold_diff", diff, 8'h1E);

    // Back-to-back: start in the done cycle
    cyc();
    issue(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    check("b2b_done1", done, 1);
    issue(8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1, 1'b1);
    cyc();
    start = 1'b0;
    check("b2b_busy", busy, 1);
    check("b2b_hold_diff", diff, 8'h7F);
    cyc();
    check("b2b_nodone", done, 0);
    cyc();
    check("b2b_done2", done, 1);

    // Operands change right after acceptance
    cyc();
    issue(8'h50, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);
    cyc();
    start = 1'b0; a = 8'hFF; b = 8'h00; bin = 1'b1;
    cyc();
    cyc();
    check("latch_done", done, 1);

    // Reset mid-RUN: no done follows
    cyc();
    start = 1'b1; a = 8'h12; b = 8'h34; bin = 1'b0;
    cyc();
    start = 1'b0; rst = 1'b1;
    cyc();
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_diff", diff, 0);
    check("mid_rst_bout", bout, 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("mid_rst_nodone", done, 0);
    end
    run_op("after_rst", 8'h34, 8'h12, 1'b0, 8'h22, 1'b0, 1'b0);

    cyc();
    cyc();
    check("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
